cdb_writeback_arbiter: RTL and testbench

//  Shares the two result (writeback) buses between the execution-unit producers: ALU1, ALU2, LD1 and LD2.

---
 rtl/cdb_writeback_arbiter_if.sv | 40 ++++
 rtl/cdb_writeback_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_writeback_arbiter_if.sv
// Producer/CDB bundle for the writeback arbiter: per-source result push with ready,
// plus the two registered result buses.
interface cdb_writeback_arbiter_if #(
    parameter int NSRC   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int DEST_W = 5
);
    logic [NSRC-1:0]        src_valid;
    logic [NSRC*TAG_W-1:0]  src_tag;
    logic [NSRC*DEST_W-1:0] src_dest;
    logic [NSRC*DATA_W-1:0] src_data;
    logic [NSRC-1:0]        src_ready;

    logic                   cdb1_valid;
    logic [TAG_W-1:0]       cdb1_tag;
    logic [DEST_W-1:0]      cdb1_dest;
    logic [DATA_W-1:0]      cdb1_data;

    logic                   cdb2_valid;
    logic [TAG_W-1:0]       cdb2_tag;
    logic [DEST_W-1:0]      cdb2_dest;
    logic [DATA_W-1:0]      cdb2_data;

    // Producer / consumer side
    modport master (
        output src_valid, src_tag, src_dest, src_data,
        input  src_ready,
        input  cdb1_valid, cdb1_tag, cdb1_dest, cdb1_data,
        input  cdb2_valid, cdb2_tag, cdb2_dest, cdb2_data
    );

    // Arbiter side
    modport slave (
        input  src_valid, src_tag, src_dest, src_data,
        output src_ready,
        output cdb1_valid, cdb1_tag, cdb1_dest, cdb1_data,
        output cdb2_valid, cdb2_tag, cdb2_dest, cdb2_data
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Two-bus writeback arbiter: per-producer FIFOs, round-robin grant of up to two heads per cycle.
// Optional macro CDB_LOAD_PRIORITY_EN: load sources are scanned before ALU sources, each group with its own pointer.
module cdb_writeback_arbiter #(
    parameter int NSRC    = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int DEST_W  = 5,
    parameter int Q_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    cdb_writeback_arbiter_if.slave bus,
    output logic                   overflow
);
    localparam int ENT_W = TAG_W + DEST_W + DATA_W;
    localparam int QP_W  = $clog2(Q_DEPTH);
    localparam int CNT_W = QP_W + 1;
    localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [ENT_W-1:0] mem [NSRC][Q_DEPTH];
    logic [CNT_W-1:0] count_reg  [NSRC];
    logic [QP_W-1:0]  wr_ptr_reg [NSRC];
    logic [QP_W-1:0]  rd_ptr_reg [NSRC];

    logic [ENT_W-1:0] in_entry [NSRC];
    logic [ENT_W-1:0] head     [NSRC];
    logic [NSRC-1:0]  nonempty;
    logic [NSRC-1:0]  ready_vec;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;

    logic             g1_valid, g2_valid;
    logic [SRC_W-1:0] g1_src, g2_src;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign in_entry[gi] = {bus.src_tag[gi*TAG_W +: TAG_W],
                                   bus.src_dest[gi*DEST_W +: DEST_W],
                                   bus.src_data[gi*DATA_W +: DATA_W]};
            assign head[gi]      = mem[gi][rd_ptr_reg[gi]];
            assign nonempty[gi]  = (count_reg[gi] != '0);
            // Ready looks only at registered occupancy, never at this cycle's grant.
            assign ready_vec[gi] = (count_reg[gi] < CNT_W'(Q_DEPTH));
            assign push[gi]      = bus.src_valid[gi] & ready_vec[gi] & ~flush;
        end
    endgenerate

    assign bus.src_ready = ready_vec;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr_reg[i]] <= in_entry[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                count_reg[i]  <= '0;
                wr_ptr_reg[i] <= '0;
                rd_ptr_reg[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NSRC; i++) begin
                count_reg[i]  <= '0;
                wr_ptr_reg[i] <= '0;
                rd_ptr_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    wr_ptr_reg[i] <= wr_ptr_reg[i] + QP_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_reg[i] <= rd_ptr_reg[i] + QP_W'(1);
                end
                if (push[i] && !pop[i]) begin
                    count_reg[i] <= count_reg[i] + CNT_W'(1);
                end else if (!push[i] && pop[i]) begin
                    count_reg[i] <= count_reg[i] - CNT_W'(1);
                end
            end
        end
    end

`ifdef CDB_LOAD_PRIORITY_EN
    localparam int NALU = NSRC / 2;
    localparam int NLD  = NSRC - NALU;
    localparam int GA_W = (NALU > 1) ? $clog2(NALU) : 1;
    localparam int GL_W = (NLD > 1) ? $clog2(NLD) : 1;

    logic [GA_W-1:0] alu_ptr_reg, alu_ptr_next;
    logic [GL_W-1:0] ld_ptr_reg, ld_ptr_next;

    // Loads first so their consumers wake up a cycle sooner; ALUs fill what is left.
    always_comb begin
        int idx;
        int ld_last;
        int alu_last;
        logic ld_hit;
        logic alu_hit;
        g1_valid     = 1'b0;
        g2_valid     = 1'b0;
        g1_src       = '0;
        g2_src       = '0;
        ld_ptr_next  = ld_ptr_reg;
        alu_ptr_next = alu_ptr_reg;
        idx          = 0;
        ld_last      = 0;
        alu_last     = 0;
        ld_hit       = 1'b0;
        alu_hit      = 1'b0;
        for (int k = 0; k < NLD; k++) begin
            idx = (int'(ld_ptr_reg) + k) % NLD;
            if (nonempty[NALU + idx] && !g2_valid) begin
                if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_src   = SRC_W'(NALU + idx);
                end else begin
                    g2_valid = 1'b1;
                    g2_src   = SRC_W'(NALU + idx);
                end
                ld_last = idx;
                ld_hit  = 1'b1;
            end
        end
        for (int k = 0; k < NALU; k++) begin
            idx = (int'(alu_ptr_reg) + k) % NALU;
            if (nonempty[idx] && !g2_valid) begin
                if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_src   = SRC_W'(idx);
                end else begin
                    g2_valid = 1'b1;
                    g2_src   = SRC_W'(idx);
                end
                alu_last = idx;
                alu_hit  = 1'b1;
            end
        end
        if (ld_hit) begin
            ld_ptr_next = GL_W'((ld_last + 1) % NLD);
        end
        if (alu_hit) begin
            alu_ptr_next = GA_W'((alu_last + 1) % NALU);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ptr_reg <= '0;
            ld_ptr_reg  <= '0;
        end else if (flush) begin
            alu_ptr_reg <= '0;
            ld_ptr_reg  <= '0;
        end else begin
            alu_ptr_reg <= alu_ptr_next;
            ld_ptr_reg  <= ld_ptr_next;
        end
    end
`else
    logic [SRC_W-1:0] rr_ptr_reg, rr_ptr_next;

    // Scan from rr_ptr; the first two non-empty sources take CDB1 then CDB2.
    always_comb begin
        int idx;
        g1_valid    = 1'b0;
        g2_valid    = 1'b0;
        g1_src      = '0;
        g2_src      = '0;
        rr_ptr_next = rr_ptr_reg;
        idx         = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NSRC;
            if (nonempty[idx] && !g2_valid) begin
                if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_src   = SRC_W'(idx);
                end else begin
                    g2_valid = 1'b1;
                    g2_src   = SRC_W'(idx);
                end
            end
        end
        if (g2_valid) begin
            rr_ptr_next = SRC_W'((int'(g2_src) + 1) % NSRC);
        end else if (g1_valid) begin
            rr_ptr_next = SRC_W'((int'(g1_src) + 1) % NSRC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (flush) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`endif

    always_comb begin
        pop = '0;
        if (g1_valid) begin
            pop[g1_src] = 1'b1;
        end
        if (g2_valid) begin
            pop[g2_src] = 1'b1;
        end
    end

    // Payload holds when idle; consumers qualify with valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cdb1_valid <= 1'b0;
            bus.cdb1_tag   <= '0;
            bus.cdb1_dest  <= '0;
            bus.cdb1_data  <= '0;
            bus.cdb2_valid <= 1'b0;
            bus.cdb2_tag   <= '0;
            bus.cdb2_dest  <= '0;
            bus.cdb2_data  <= '0;
        end else if (flush) begin
            bus.cdb1_valid <= 1'b0;
            bus.cdb2_valid <= 1'b0;
        end else begin
            bus.cdb1_valid <= g1_valid;
            bus.cdb2_valid <= g2_valid;
            if (g1_valid) begin
                bus.cdb1_tag  <= head[g1_src][ENT_W-1 -: TAG_W];
                bus.cdb1_dest <= head[g1_src][DATA_W+DEST_W-1 -: DEST_W];
                bus.cdb1_data <= head[g1_src][DATA_W-1:0];
            end
            if (g2_valid) begin
                bus.cdb2_tag  <= head[g2_src][ENT_W-1 -: TAG_W];
                bus.cdb2_dest <= head[g2_src][DATA_W+DEST_W-1 -: DEST_W];
                bus.cdb2_data <= head[g2_src][DATA_W-1:0];
            end
        end
    end

    // Sticky until rst; a push discarded by flush is not an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (!flush && |(bus.src_valid & ~ready_vec)) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter: vector table for streaming/round-robin,
// hand sequences for reset, latency, overflow, flush, async reset and grant order.
module tb_cdb_writeback_arbiter;
    localparam int NSRC = 4, DATA_W = 32, TAG_W = 5, DEST_W = 5, Q_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic overflow;
    int total = 0;
    int bad = 0;

    cdb_writeback_arbiter_if #(.NSRC(NSRC), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEST_W(DEST_W)) bus();

    cdb_writeback_arbiter #(
        .NSRC(NSRC), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEST_W(DEST_W), .Q_DEPTH(Q_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  vld;
        logic [19:0] tags;
        logic [3:0]  rdy;
        logic        v1;
        logic [4:0]  t1;
        logic        v2;
        logic [4:0]  t2;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [31:0] data_of(input logic [4:0] t);
        return 32'hC0DE_0000 | {27'd0, t};
    endfunction

    function automatic logic [4:0] dest_of(input logic [4:0] t);
        return ~t;
    endfunction

    function automatic vec_t mk(input logic [3:0] vld, input logic [4:0] s3, input logic [4:0] s2,
                                input logic [4:0] s1, input logic [4:0] s0, input logic [3:0] rdy,
                                input logic v1, input logic [4:0] t1, input logic v2, input logic [4:0] t2);
        vec_t v;
        v.vld  = vld;
        v.tags = {s3, s2, s1, s0};
        v.rdy  = rdy;
        v.v1   = v1;
        v.t1   = t1;
        v.v2   = v2;
        v.t2   = t2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [19:0] tags);
        bus.src_valid = vld;
        bus.src_tag   = tags;
        for (int i = 0; i < NSRC; i++) begin
            bus.src_dest[i*DEST_W +: DEST_W] = dest_of(tags[i*TAG_W +: TAG_W]);
            bus.src_data[i*DATA_W +: DATA_W] = data_of(tags[i*TAG_W +: TAG_W]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cdb(input string nm, input logic v1, input logic [4:0] t1,
                           input logic v2, input logic [4:0] t2);
        chk({nm, ".cdb1_valid"}, {31'd0, bus.cdb1_valid}, {31'd0, v1});
        if (v1) begin
            chk({nm, ".cdb1_tag"},  {27'd0, bus.cdb1_tag},  {27'd0, t1});
            chk({nm, ".cdb1_dest"}, {27'd0, bus.cdb1_dest}, {27'd0, dest_of(t1)});
            chk({nm, ".cdb1_data"}, bus.cdb1_data, data_of(t1));
        end
        chk({nm, ".cdb2_valid"}, {31'd0, bus.cdb2_valid}, {31'd0, v2});
        if (v2) begin
            chk({nm, ".cdb2_tag"},  {27'd0, bus.cdb2_tag},  {27'd0, t2});
            chk({nm, ".cdb2_dest"}, {27'd0, bus.cdb2_dest}, {27'd0, dest_of(t2)});
            chk({nm, ".cdb2_data"}, bus.cdb2_data, data_of(t2));
        end
        $display("%s: cdb1=%b/%0d cdb2=%b/%0d ready=%b overflow=%b", nm,
                 bus.cdb1_valid, bus.cdb1_tag, bus.cdb2_valid, bus.cdb2_tag, bus.src_ready, overflow);
    endtask

    initial begin
        // Streaming table, starting from empty FIFOs and rr_ptr=0.
        vecs[0]  = mk(4'b1111,  3,  2,  1,  0, 4'b1111, 0,  0, 0,  0);
        vecs[1]  = mk(4'b1111,  7,  6,  5,  4, 4'b0011, 1,  0, 1,  1);
        vecs[2]  = mk(4'b0011,  0,  0,  9,  8, 4'b1100, 1,  2, 1,  3);
        vecs[3]  = mk(4'b1100, 11, 10,  0,  0, 4'b0011, 1,  4, 1,  5);
        vecs[4]  = mk(4'b0000,  0,  0,  0,  0, 4'b1111, 1,  6, 1,  7);
        vecs[5]  = mk(4'b0000,  0,  0,  0,  0, 4'b1111, 1,  8, 1,  9);
        vecs[6]  = mk(4'b0000,  0,  0,  0,  0, 4'b1111, 1, 10, 1, 11);
        vecs[7]  = mk(4'b0000,  0,  0,  0,  0, 4'b1111, 0,  0, 0,  0);
        vecs[8]  = mk(4'b0010,  0,  0, 12,  0, 4'b1111, 0,  0, 0,  0);
        vecs[9]  = mk(4'b0000,  0,  0,  0,  0, 4'b1111, 1, 12, 0,  0);
        vecs[10] = mk(4'b1001, 14,  0,  0, 13, 4'b1111, 0,  0, 0,  0);
        vecs[11] = mk(4'b0000,  0,  0,  0,  0, 4'b1111, 1, 14, 1, 13);
        vecs[12] = mk(4'b0101,  0, 16,  0, 15, 4'b1111, 0,  0, 0,  0);
        vecs[13] = mk(4'b0000,  0,  0,  0,  0, 4'b1111, 1, 16, 1, 15);

        // Reset state
        rst   = 1'b1;
        flush = 1'b0;
        drive(4'b0000, 20'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.src_ready", {28'd0, bus.src_ready}, 32'hF);
        chk("reset.cdb1_valid", {31'd0, bus.cdb1_valid}, 32'd0);
        chk("reset.cdb2_valid", {31'd0, bus.cdb2_valid}, 32'd0);
        chk("reset.overflow", {31'd0, overflow}, 32'd0);
        chk("reset.cdb1_tag", {27'd0, bus.cdb1_tag}, 32'd0);
        chk("reset.cdb2_data", bus.cdb2_data, 32'd0);

        // Single push: visible after the second edge
        bus.src_valid = 4'b0001;
        bus.src_tag   = 20'd3;
        bus.src_dest  = 20'd7;
        bus.src_data  = {96'd0, 32'hDEAD_BEEF};
        tick();
        chk("single.edge1_valid", {31'd0, bus.cdb1_valid}, 32'd0);
        drive(4'b0000, 20'd0);
        tick();
        chk("single.cdb1_valid", {31'd0, bus.cdb1_valid}, 32'd1);
        chk("single.cdb1_tag", {27'd0, bus.cdb1_tag}, 32'd3);
        chk("single.cdb1_dest", {27'd0, bus.cdb1_dest}, 32'd7);
        chk("single.cdb1_data", bus.cdb1_data, 32'hDEAD_BEEF);
        chk("single.cdb2_valid", {31'd0, bus.cdb2_valid}, 32'd0);
        $display("single: cdb1=%b/%0d data=%h", bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_data);
        tick();
        chk("single.after_valid", {31'd0, bus.cdb1_valid}, 32'd0);

        // Flush returns rr_ptr to 0 before the table
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_cdb("preflush", 1'b0, 5'd0, 1'b0, 5'd0);

        for (int r = 0; r < 14; r++) begin
            drive(vecs[r].vld, vecs[r].tags);
            tick();
            chk($sformatf("row%0d.src_ready", r), {28'd0, bus.src_ready}, {28'd0, vecs[r].rdy});
            chk($sformatf("row%0d.overflow", r), {31'd0, overflow}, 32'd0);
            chk_cdb($sformatf("row%0d", r), vecs[r].v1, vecs[r].t1, vecs[r].v2, vecs[r].t2);
        end
        drive(4'b0000, 20'd0);

        // Overflow: source 2 fills while 0/1 hold the buses, third push is dropped
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(4'b0111, {5'd0, 5'd22, 5'd21, 5'd20});
        tick();
        chk_cdb("ovf.e1", 1'b0, 5'd0, 1'b0, 5'd0);
        drive(4'b0100, {5'd0, 5'd23, 5'd0, 5'd0});
        tick();
        chk("ovf.e2.src_ready", {28'd0, bus.src_ready}, 32'hB);
        chk("ovf.e2.overflow", {31'd0, overflow}, 32'd0);
        chk_cdb("ovf.e2", 1'b1, 5'd20, 1'b1, 5'd21);
        drive(4'b0100, {5'd0, 5'd24, 5'd0, 5'd0});
        tick();
        chk("ovf.e3.overflow", {31'd0, overflow}, 32'd1);
        chk_cdb("ovf.e3", 1'b1, 5'd22, 1'b0, 5'd0);
        drive(4'b0000, 20'd0);
        tick();
        chk_cdb("ovf.e4", 1'b1, 5'd23, 1'b0, 5'd0);
        tick();
        chk_cdb("ovf.e5", 1'b0, 5'd0, 1'b0, 5'd0);

        // Flush with three FIFOs occupied and all producers pushing
        drive(4'b0111, {5'd0, 5'd27, 5'd26, 5'd25});
        tick();
        chk_cdb("flush.fill", 1'b0, 5'd0, 1'b0, 5'd0);
        flush = 1'b1;
        drive(4'b1111, {5'd31, 5'd30, 5'd29, 5'd28});
        tick();
        flush = 1'b0;
        drive(4'b0000, 20'd0);
        chk_cdb("flush.e1", 1'b0, 5'd0, 1'b0, 5'd0);
        chk("flush.src_ready", {28'd0, bus.src_ready}, 32'hF);
        chk("flush.overflow_kept", {31'd0, overflow}, 32'd1);
        tick();
        chk_cdb("flush.e2", 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk_cdb("flush.e3", 1'b0, 5'd0, 1'b0, 5'd0);

        // Asynchronous reset between edges clears outputs and overflow
        drive(4'b0001, {15'd0, 5'd5});
        tick();
        drive(4'b0000, 20'd0);
        tick();
        chk_cdb("arst.before", 1'b1, 5'd5, 1'b0, 5'd0);
        rst = 1'b1;
        #2;
        chk("arst.cdb1_valid", {31'd0, bus.cdb1_valid}, 32'd0);
        chk("arst.overflow", {31'd0, overflow}, 32'd0);
        chk("arst.src_ready", {28'd0, bus.src_ready}, 32'hF);
        @(negedge clk);
        rst = 1'b0;

        // Grant order with ALU1, ALU2 and LD1 queued, pointers at reset
        drive(4'b0111, {5'd0, 5'd4, 5'd2, 5'd1});
        tick();
        drive(4'b0000, 20'd0);
        tick();
`ifdef CDB_LOAD_PRIORITY_EN
        chk_cdb("order", 1'b1, 5'd4, 1'b1, 5'd1);
`else
        chk_cdb("order", 1'b1, 5'd1, 1'b1, 5'd2);
`endif
        tick();
`ifdef CDB_LOAD_PRIORITY_EN
        chk_cdb("order.next", 1'b1, 5'd2, 1'b0, 5'd0);
`else
        chk_cdb("order.next", 1'b1, 5'd4, 1'b0, 5'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
